// File: rtl/servo_pkg.sv
// Shared constants, state encoding and helpers for the servo angle-to-duty path.
package servo_pkg;

  localparam int TICKS_PER_FRAME = 4000;
  localparam int CICLO_W         = 12;
  localparam int ANGLE_W         = 8;
  localparam int PROD_W          = 16;

  localparam int DEF_MIN_TICKS   = 200;
  localparam int DEF_SPAN_TICKS  = 200;
  localparam int DEF_MAX_ANGLE   = 180;
  localparam int DEF_STEP_TICKS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_RAMP    = 2'd2
  } servo_state_e;

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a,
                                                     input logic [ANGLE_W-1:0] max_a);
    return (a > max_a) ? max_a : a;
  endfunction

endpackage

// File: rtl/serial_div.sv
// Unsigned 16/8 restoring divider: one quotient bit per cycle, 16 iterations,
// done pulses the cycle after the last iteration. A new start aborts any division.
module serial_div
  import servo_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [PROD_W-1:0]  dividend_i,
  input  logic [7:0]         divisor_i,
  output logic               done_o,
  output logic [CICLO_W-1:0] quotient_o
);

  logic [PROD_W-1:0] quo_q, quo_d;
  logic [7:0]        rem_q, rem_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        rem_sh_s;

  // Shift-subtract step; the dividend shifts out of quo_q as quotient bits shift in
  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rem_sh_s = {rem_q, quo_q[PROD_W-1]};
    if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = 8'd0;
      cnt_d  = 4'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_sh_s >= {1'b0, divisor_i}) begin
        rem_d = 8'(rem_sh_s - {1'b0, divisor_i});
        quo_d = {quo_q[PROD_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh_s[7:0];
        quo_d = {quo_q[PROD_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q  <= '0;
      rem_q  <= 8'd0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q[CICLO_W-1:0];

endmodule

// File: rtl/servo_angle_ramp.sv
// Angle request -> duty ticks for the servo PWM stage, slewed once per frame.
// Macro SERVO_RAMP_EN enables the slew-limited ramp; without it the duty jumps to target.
module servo_angle_ramp
  import servo_pkg::*;
#(
  parameter int MIN_TICKS  = DEF_MIN_TICKS,
  parameter int SPAN_TICKS = DEF_SPAN_TICKS,
  parameter int MAX_ANGLE  = DEF_MAX_ANGLE,
  parameter int FRAME_CLKS = 1000000
`ifdef SERVO_RAMP_EN
  ,
  parameter int STEP_TICKS = DEF_STEP_TICKS
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ANGLE_W-1:0] angle_i,
  input  logic               angle_valid_i,
  output logic               angle_ready_o,
  input  logic               enable_i,
  output logic [CICLO_W-1:0] ciclo_o,
  output logic               at_target_o,
  output logic               frame_tick_o
);

  localparam int FCW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [FCW-1:0]     FRAME_LAST = FCW'(FRAME_CLKS - 1);
  localparam logic [CICLO_W-1:0] MID_TICKS  = CICLO_W'(MIN_TICKS + SPAN_TICKS / 2);
  localparam logic [CICLO_W-1:0] MIN_T      = CICLO_W'(MIN_TICKS);
  localparam logic [ANGLE_W-1:0] MAX_A      = ANGLE_W'(MAX_ANGLE);

  servo_state_e       state_q, state_d;
  logic [ANGLE_W-1:0] ang_q, ang_d;
  logic               start_q, start_d;
  logic [CICLO_W-1:0] target_q, target_d;
  logic [CICLO_W-1:0] pos_q, pos_d;
  logic               at_q, at_d;
  logic [CICLO_W-1:0] ciclo_q, ciclo_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic               ftick_q, ftick_d;

  logic               ready_s;
  logic               accept_s;
  logic               div_done_s;
  logic [CICLO_W-1:0] quot_s;
  logic [CICLO_W-1:0] new_tgt_s;
  logic [PROD_W-1:0]  product_s;
`ifdef SERVO_RAMP_EN
  logic [CICLO_W-1:0] diff_s;
  localparam logic [CICLO_W-1:0] STEP_T = CICLO_W'(STEP_TICKS);
`endif

  assign ready_s    = (state_q != ST_CONVERT);
  assign accept_s   = angle_valid_i && ready_s;
  assign product_s  = PROD_W'(ang_q) * PROD_W'(SPAN_TICKS);
  assign new_tgt_s  = MIN_T + quot_s;

  // Divider is launched the cycle after acceptance so the target lands 18 edges later
  serial_div u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_q),
    .dividend_i (product_s),
    .divisor_i  (MAX_A),
    .done_o     (div_done_s),
    .quotient_o (quot_s)
  );

  // Next-state logic: control FSM, target/position update, frame counter, duty output
  always_comb begin
    state_d  = state_q;
    ang_d    = ang_q;
    start_d  = 1'b0;
    target_d = target_q;
    pos_d    = pos_q;
    at_d     = at_q;
`ifdef SERVO_RAMP_EN
    diff_s   = (target_q > pos_q) ? (target_q - pos_q) : (pos_q - target_q);
`endif
    case (state_q)
      ST_IDLE, ST_RAMP: begin
        if (accept_s) begin
          ang_d   = clamp_angle(angle_i, MAX_A);
          start_d = 1'b1;
          state_d = ST_CONVERT;
`ifdef SERVO_RAMP_EN
        end else if ((state_q == ST_RAMP) && ftick_q) begin
          // Final step snaps to target so the ramp never overshoots
          if (diff_s <= STEP_T) begin
            pos_d   = target_q;
            at_d    = 1'b1;
            state_d = ST_IDLE;
          end else if (target_q > pos_q) begin
            pos_d = pos_q + STEP_T;
          end else begin
            pos_d = pos_q - STEP_T;
          end
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_CONVERT: begin
        if (div_done_s) begin
          target_d = new_tgt_s;
`ifdef SERVO_RAMP_EN
          if (new_tgt_s == pos_q) begin
            at_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            at_d    = 1'b0;
            state_d = ST_RAMP;
          end
`else
          pos_d   = new_tgt_s;
          at_d    = 1'b1;
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_CONVERT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fcnt_q == FRAME_LAST) begin
      fcnt_d  = '0;
      ftick_d = 1'b1;
    end else begin
      fcnt_d  = fcnt_q + FCW'(1);
      ftick_d = 1'b0;
    end

    if (enable_i) begin
      ciclo_d = pos_q;
    end else begin
      ciclo_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ang_q    <= '0;
      start_q  <= 1'b0;
      target_q <= MID_TICKS;
      pos_q    <= MID_TICKS;
      at_q     <= 1'b1;
      ciclo_q  <= '0;
      fcnt_q   <= '0;
      ftick_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ang_q    <= ang_d;
      start_q  <= start_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      at_q     <= at_d;
      ciclo_q  <= ciclo_d;
      fcnt_q   <= fcnt_d;
      ftick_q  <= ftick_d;
    end
  end

  assign angle_ready_o = ready_s;
  assign ciclo_o       = ciclo_q;
  assign at_target_o   = at_q;
  assign frame_tick_o  = ftick_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with FRAME_CLKS=100; covers both SERVO_RAMP_EN builds.
module tb_servo_angle_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  angle;
  logic        valid;
  logic        ready;
  logic        enable;
  logic [11:0] ciclo;
  logic        at_tgt;
  logic        ftick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servo_angle_ramp #(.FRAME_CLKS(100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .angle_i       (angle),
    .angle_valid_i (valid),
    .angle_ready_o (ready),
    .enable_i      (enable),
    .ciclo_o       (ciclo),
    .at_target_o   (at_tgt),
    .frame_tick_o  (ftick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int a);
    check_eq("ready_before_accept", 32'(ready), 32'd1);
    angle = 8'(a);
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic settle(input int a, input int exp, input string tag);
    int n;
    accept(a);
    tick(18);
    n = 0;
    while (!at_tgt && n < 7000) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_settled"}, 32'(at_tgt), 32'd1);
    tick(1);
    check_eq(tag, 32'(ciclo), 32'(exp));
  endtask

  task automatic wait_change(input int prev);
    int n;
    n = 0;
    while (int'(ciclo) == prev && n < 300) begin
      tick(1);
      n++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ciclo"}, 32'(ciclo), 32'd0);
    check_eq({tag, "_at"}, 32'(at_tgt), 32'd1);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    check_eq({tag, "_ftick"}, 32'(ftick), 32'd0);
  endtask

  initial begin
    int n;
    int exp;
    rst    = 1'b1;
    enable = 1'b1;
    valid  = 1'b0;
    angle  = 8'd0;
    tick(2);
    check_reset_state("reset");
    rst = 1'b0;
    tick(1);
    check_eq("post_reset_ciclo", 32'(ciclo), 32'd300);

    // Angle 90 converts to the reset midpoint: target 300, AtTarget never drops
    accept(90);
    check_eq("a90_ready_e0", 32'(ready), 32'd0);
    tick(17);
    check_eq("a90_ready_e17", 32'(ready), 32'd0);
    check_eq("a90_at_e17", 32'(at_tgt), 32'd1);
    tick(1);
    check_eq("a90_ready_e18", 32'(ready), 32'd1);
    check_eq("a90_at_e18", 32'(at_tgt), 32'd1);
    tick(1);
    check_eq("a90_ciclo", 32'(ciclo), 32'd300);

    // Frame tick: one-cycle pulse every 100 clocks
    n = 0;
    while (!ftick && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("ftick_seen", 32'(ftick), 32'd1);
    tick(1);
    check_eq("ftick_pulse_width", 32'(ftick), 32'd0);
    tick(98);
    check_eq("ftick_before_wrap", 32'(ftick), 32'd0);
    tick(1);
    check_eq("ftick_period", 32'(ftick), 32'd1);

    // De-energise and re-energise while idle
    enable = 1'b0;
    tick(1);
    check_eq("disable_ciclo", 32'(ciclo), 32'd0);
    enable = 1'b1;
    tick(1);
    check_eq("enable_ciclo", 32'(ciclo), 32'd300);

`ifndef SERVO_RAMP_EN
    // Direct update: Pos changes at +18, Ciclo follows at +19
    accept(0);
    tick(17);
    check_eq("a0_ciclo_e17", 32'(ciclo), 32'd300);
    tick(1);
    check_eq("a0_ciclo_e18", 32'(ciclo), 32'd300);
    check_eq("a0_at_e18", 32'(at_tgt), 32'd1);
    check_eq("a0_ready_e18", 32'(ready), 32'd1);
    tick(1);
    check_eq("a0_ciclo_e19", 32'(ciclo), 32'd200);

    settle(255, 400, "clamp255");
    settle(1, 201, "trunc1");
    settle(179, 398, "trunc179");
    settle(45, 250, "a45");

    // Reset during CONVERT aborts the divider; no late target update
    accept(0);
    tick(5);
    rst = 1'b1;
    tick(1);
    check_reset_state("rst_convert");
    rst = 1'b0;
    tick(30);
    check_eq("rst_convert_ciclo", 32'(ciclo), 32'd300);
    check_eq("rst_convert_at", 32'(at_tgt), 32'd1);
`else
    // Ramp 300 -> 200 in 25 steps of 4
    accept(0);
    tick(18);
    check_eq("down_at_drop", 32'(at_tgt), 32'd0);
    exp = 300;
    for (int i = 0; i < 25; i++) begin
      wait_change(exp);
      exp = exp - 4;
      check_eq("down_step", 32'(ciclo), 32'(exp));
    end
    check_eq("down_at_end", 32'(at_tgt), 32'd1);
    tick(250);
    check_eq("down_no_overshoot", 32'(ciclo), 32'd200);

    // Ramp toward 400 (clamped 255), redirect at 340
    accept(255);
    tick(18);
    exp = 200;
    for (int i = 0; i < 35; i++) begin
      wait_change(exp);
      exp = exp + 4;
      check_eq("up_step", 32'(ciclo), 32'(exp));
    end
    accept(0);
    check_eq("redirect_ready_e0", 32'(ready), 32'd0);
    tick(17);
    check_eq("redirect_ready_e17", 32'(ready), 32'd0);
    check_eq("redirect_hold", 32'(ciclo), 32'd340);
    tick(1);
    check_eq("redirect_ready_e18", 32'(ready), 32'd1);
    check_eq("redirect_at", 32'(at_tgt), 32'd0);
    wait_change(340);
    check_eq("redirect_first_down", 32'(ciclo), 32'd336);

    // Disabled output while position keeps ramping to 200
    enable = 1'b0;
    tick(1);
    check_eq("ramp_disable_ciclo", 32'(ciclo), 32'd0);
    tick(4000);
    check_eq("ramp_disable_at", 32'(at_tgt), 32'd1);
    check_eq("ramp_disable_still0", 32'(ciclo), 32'd0);
    enable = 1'b1;
    tick(1);
    check_eq("ramp_reenable_ciclo", 32'(ciclo), 32'd200);

    settle(255, 400, "clamp255");
    settle(1, 201, "trunc1");
    settle(45, 250, "a45");

    // Reset during RAMP
    accept(180);
    tick(18);
    wait_change(250);
    check_eq("rst_ramp_step", 32'(ciclo), 32'd254);
    rst = 1'b1;
    tick(1);
    check_reset_state("rst_ramp");
    rst = 1'b0;
    tick(1);
    check_eq("rst_ramp_ciclo", 32'(ciclo), 32'd300);

    // Reset during CONVERT
    accept(0);
    tick(5);
    rst = 1'b1;
    tick(1);
    check_reset_state("rst_convert");
    rst = 1'b0;
    tick(30);
    check_eq("rst_convert_ciclo", 32'(ciclo), 32'd300);
    check_eq("rst_convert_at", 32'(at_tgt), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
